// File: rtl/wb_pkg.sv
// Shared types and defaults for the write-back stage and its load formatter.
package wb_pkg;

  localparam int XLEN_DEF      = 32;
  localparam int REG_COUNT_DEF = 32;
  localparam int ADDR_W_DEF    = $clog2(REG_COUNT_DEF);

  typedef enum logic [2:0] {
    LD_LB  = 3'd0,
    LD_LH  = 3'd1,
    LD_LW  = 3'd2,
    LD_LBU = 3'd4,
    LD_LHU = 3'd5
  } ld_funct3_e;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] rd;
    logic [XLEN_DEF-1:0]   data;
    logic                  err;
  } wb_req_t;

endpackage

// File: rtl/wb_stage_load_align.sv
// Combinational load formatter: picks the byte/halfword addressed by the offset
// and sign- or zero-extends it; flags misaligned or unknown load types.
module load_align
  import wb_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      offset_i,
  input  logic [XLEN-1:0] word_i,
  output logic [XLEN-1:0] data_o,
  output logic            err_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Byte/halfword lane selection and extension per load type.
  always_comb begin
    byte_s = word_i[{offset_i, 3'b000} +: 8];
    half_s = offset_i[1] ? word_i[31:16] : word_i[15:0];
    data_o = '0;
    err_o  = 1'b0;
    case (ld_funct3_e'(funct3_i))
      LD_LB:  data_o = {{(XLEN-8){byte_s[7]}}, byte_s};
      LD_LBU: data_o = {{(XLEN-8){1'b0}}, byte_s};
      LD_LH: begin
        data_o = {{(XLEN-16){half_s[15]}}, half_s};
        err_o  = offset_i[0];
      end
      LD_LHU: begin
        data_o = {{(XLEN-16){1'b0}}, half_s};
        err_o  = offset_i[0];
      end
      LD_LW: begin
        data_o = word_i;
        err_o  = (offset_i != 2'd0);
      end
      default: begin
        data_o = '0;
        err_o  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: arbitrates ALU and load results (load first, with an ALU
// anti-starvation grant) and issues one registered register-file write per cycle.
module wb_stage
  import wb_pkg::*;
#(
  parameter int XLEN         = XLEN_DEF,
  parameter int REG_COUNT    = REG_COUNT_DEF,
  parameter int ADDR_W       = $clog2(REG_COUNT),
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [ADDR_W-1:0]    alu_rd,
  input  logic [XLEN-1:0]      alu_data,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [ADDR_W-1:0]    ld_rd,
  input  logic [2:0]           ld_funct3,
  input  logic [1:0]           ld_offset,
  input  logic [XLEN-1:0]      ld_data,
  output logic [REG_COUNT-1:0] rf_wen,
  output logic [XLEN-1:0]      rf_wdata,
  output logic                 fwd_valid,
  output logic [ADDR_W-1:0]    fwd_rd,
  output logic                 ld_err,
  output logic [31:0]          wb_count
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0]     starve_q, starve_d;
  logic [REG_COUNT-1:0] wen_q, wen_d;
  logic [XLEN-1:0]      wdata_q, wdata_d;
  logic                 fwd_valid_q, fwd_valid_d;
  logic [ADDR_W-1:0]    fwd_rd_q, fwd_rd_d;
  logic                 ld_err_q, ld_err_d;
  logic [31:0]          count_q, count_d;

  logic [XLEN-1:0] ld_fmt_s;
  logic            ld_fmt_err_s;
  logic            force_s, ld_acc_s, alu_acc_s, commit_s;
  wb_req_t         req_s;

  load_align #(.XLEN(XLEN)) u_align (
    .funct3_i (ld_funct3),
    .offset_i (ld_offset),
    .word_i   (ld_data),
    .data_o   (ld_fmt_s),
    .err_o    (ld_fmt_err_s)
  );

  // Handshake arbitration and starvation tracking.
  always_comb begin
    force_s   = (starve_q == LIMIT);
    ld_ready  = !force_s;
    alu_ready = force_s || !ld_valid;
    ld_acc_s  = ld_valid && ld_ready;
    alu_acc_s = alu_valid && alu_ready && !ld_acc_s;
    if (alu_valid && !alu_ready) begin
      starve_d = force_s ? starve_q : starve_q + CNT_W'(1);
    end else begin
      starve_d = '0;
    end
  end

  // Select the winning request and build the next write-port state.
  always_comb begin
    req_s = '0;
    if (ld_acc_s) begin
      req_s.rd   = ld_rd;
      req_s.data = ld_fmt_s;
      req_s.err  = ld_fmt_err_s;
    end else begin
      req_s.rd   = alu_rd;
      req_s.data = alu_data;
      req_s.err  = 1'b0;
    end
    // x0 and dropped loads are consumed without a register write.
    commit_s    = (ld_acc_s || alu_acc_s) && !req_s.err && (req_s.rd != '0);
    wen_d       = '0;
    if (commit_s) begin
      wen_d[req_s.rd] = 1'b1;
    end else begin
      wen_d = '0;
    end
    wdata_d     = commit_s ? req_s.data : wdata_q;
    fwd_rd_d    = commit_s ? req_s.rd : fwd_rd_q;
    fwd_valid_d = commit_s;
    ld_err_d    = ld_acc_s && req_s.err;
    count_d     = commit_s ? count_q + 32'd1 : count_q;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_q    <= '0;
      wen_q       <= '0;
      wdata_q     <= '0;
      fwd_valid_q <= 1'b0;
      fwd_rd_q    <= '0;
      ld_err_q    <= 1'b0;
      count_q     <= 32'd0;
    end else begin
      starve_q    <= starve_d;
      wen_q       <= wen_d;
      wdata_q     <= wdata_d;
      fwd_valid_q <= fwd_valid_d;
      fwd_rd_q    <= fwd_rd_d;
      ld_err_q    <= ld_err_d;
      count_q     <= count_d;
    end
  end

  assign rf_wen    = wen_q;
  assign rf_wdata  = wdata_q;
  assign fwd_valid = fwd_valid_q;
  assign fwd_rd    = fwd_rd_q;
  assign ld_err    = ld_err_q;
  assign wb_count  = count_q;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed vectors plus randomized traffic
// compared against a cycle-level behavioural model.
module tb_wb_stage;
  import wb_pkg::*;

  localparam int XLEN = 32;
  localparam int REG_COUNT = 32;
  localparam int ADDR_W = 5;
  localparam int LIMIT = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              alu_valid, alu_ready, ld_valid, ld_ready;
  logic [ADDR_W-1:0] alu_rd, ld_rd, fwd_rd;
  logic [XLEN-1:0]   alu_data, ld_data, rf_wdata;
  logic [2:0]        ld_funct3;
  logic [1:0]        ld_offset;
  logic [31:0]       rf_wen;
  logic              fwd_valid, ld_err;
  logic [31:0]       wb_count;

  wb_stage #(.XLEN(XLEN), .REG_COUNT(REG_COUNT), .ADDR_W(ADDR_W), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_funct3(ld_funct3),
    .ld_offset(ld_offset), .ld_data(ld_data),
    .rf_wen(rf_wen), .rf_wdata(rf_wdata), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
    .ld_err(ld_err), .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model state
  int          m_cnt = 0;
  logic [31:0] e_wen = 0, e_wdata = 0, e_count = 0;
  logic [4:0]  e_rd = 0;
  logic        e_fv = 0, e_err = 0;
  logic        acc_alu, acc_ld;

  typedef struct {
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [31:0] word;
    logic [31:0] exp_data;
    logic        exp_err;
  } ld_vec_t;

  ld_vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void fmt(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] w,
                              output logic [31:0] d, output logic err);
    logic [31:0] b, h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (8 * off)) & 32'hFFFF;
    d = 32'd0;
    err = 1'b0;
    case (f3)
      3'd0: d = (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
      3'd1: begin d = (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h; err = (off % 2 != 0); end
      3'd2: begin d = w; err = (off != 2'd0); end
      3'd4: d = b;
      3'd5: begin d = h; err = (off % 2 != 0); end
      default: err = 1'b1;
    endcase
  endfunction

  // Inputs already driven (just after a negedge); run one clock and check.
  task automatic cycle();
    logic        al_r, ld_r, er, rst_now;
    logic [31:0] d;
    logic [4:0]  rd;
    #1;
    rst_now = rst_n;
    acc_alu = 1'b0;
    acc_ld  = 1'b0;
    e_fv = 1'b0; e_err = 1'b0; e_wen = 32'd0;
    if (rst_now) begin
      ld_r = (m_cnt != LIMIT);
      al_r = (m_cnt == LIMIT) || !ld_valid;
      chk("ld_ready", ld_ready, ld_r);
      chk("alu_ready", alu_ready, al_r);
      acc_ld  = ld_valid && ld_r;
      acc_alu = alu_valid && al_r;
      if (alu_valid && !al_r) m_cnt = (m_cnt < LIMIT) ? m_cnt + 1 : LIMIT;
      else m_cnt = 0;
      if (acc_ld || acc_alu) begin
        if (acc_ld) begin fmt(ld_funct3, ld_offset, ld_data, d, er); rd = ld_rd; end
        else begin d = alu_data; er = 1'b0; rd = alu_rd; end
        e_err = acc_ld && er;
        if (!er && rd != 5'd0) begin
          e_wen = 32'd1 << rd; e_wdata = d; e_rd = rd; e_fv = 1'b1; e_count = e_count + 32'd1;
        end
      end
    end else begin
      m_cnt = 0; e_wdata = 32'd0; e_rd = 5'd0; e_count = 32'd0;
    end
    @(negedge clk);
    chk("rf_wen", rf_wen, e_wen);
    chk("rf_wdata", rf_wdata, e_wdata);
    chk("fwd_valid", {31'd0, fwd_valid}, {31'd0, e_fv});
    chk("ld_err", {31'd0, ld_err}, {31'd0, e_err});
    chk("wb_count", wb_count, e_count);
    if (e_fv || !rst_now) chk("fwd_rd", {27'd0, fwd_rd}, {27'd0, e_rd});
  endtask

  initial begin
    logic [31:0] cnt_before;
    rst_n = 1'b0; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_valid = 1'b0; ld_rd = '0; ld_funct3 = '0; ld_offset = '0; ld_data = '0;

    vecs[0] = '{3'd0, 2'd3, 32'h80FF_0000, 32'hFFFF_FF80, 1'b0};
    vecs[1] = '{3'd5, 2'd2, 32'h8001_1234, 32'h0000_8001, 1'b0};
    vecs[2] = '{3'd1, 2'd1, 32'h8001_1234, 32'h0000_0000, 1'b1};
    vecs[3] = '{3'd4, 2'd0, 32'h1234_ABCD, 32'h0000_00CD, 1'b0};
    vecs[4] = '{3'd0, 2'd0, 32'h1234_ABCD, 32'hFFFF_FFCD, 1'b0};
    vecs[5] = '{3'd1, 2'd0, 32'h1234_ABCD, 32'hFFFF_ABCD, 1'b0};
    vecs[6] = '{3'd2, 2'd0, 32'h1234_ABCD, 32'h1234_ABCD, 1'b0};
    vecs[7] = '{3'd2, 2'd2, 32'h1234_ABCD, 32'h0000_0000, 1'b1};
    vecs[8] = '{3'd3, 2'd0, 32'h1234_ABCD, 32'h0000_0000, 1'b1};
    vecs[9] = '{3'd5, 2'd0, 32'h1234_ABCD, 32'h0000_ABCD, 1'b0};

    @(negedge clk);
    cycle(); cycle();
    rst_n = 1'b1;

    // ALU-only write to x5
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
    cycle();
    alu_valid = 1'b0;
    chk("alu_x5_wen", rf_wen, 32'h0000_0020);
    chk("alu_x5_data", rf_wdata, 32'hDEAD_BEEF);
    chk("alu_x5_count", wb_count, 32'd1);

    // Load formatting vectors
    for (int i = 0; i < 10; i++) begin
      ld_valid = 1'b1; ld_rd = 5'd9; ld_funct3 = vecs[i].f3;
      ld_offset = vecs[i].off; ld_data = vecs[i].word;
      cycle();
      ld_valid = 1'b0;
      chk("vec_err", {31'd0, ld_err}, {31'd0, vecs[i].exp_err});
      chk("vec_wen", rf_wen, vecs[i].exp_err ? 32'd0 : 32'h0000_0200);
      if (!vecs[i].exp_err) chk("vec_data", rf_wdata, vecs[i].exp_data);
    end

    // ALU write to x0
    cnt_before = wb_count;
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h0000_1234;
    #1 chk("x0_alu_ready", {31'd0, alu_ready}, 32'd1);
    cycle();
    alu_valid = 1'b0;
    chk("x0_wen", rf_wen, 32'd0);
    chk("x0_count", wb_count, cnt_before);

    // Contention: loads win LIMIT cycles, then the ALU is force-granted
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = $urandom;
    ld_valid = 1'b1; ld_funct3 = 3'd2; ld_offset = 2'd0; ld_rd = 5'd11; ld_data = $urandom;
    for (int i = 0; i < 15; i++) begin
      #1 chk("contend_ld_ready", {31'd0, ld_ready}, (i % 5 == 4) ? 32'd0 : 32'd1);
      chk("contend_alu_ready", {31'd0, alu_ready}, (i % 5 == 4) ? 32'd1 : 32'd0);
      cycle();
      if (acc_ld) begin ld_rd = 5'($urandom_range(1, 31)); ld_data = $urandom; end
      if (acc_alu) begin alu_rd = 5'($urandom_range(1, 31)); alu_data = $urandom; end
    end
    ld_valid = 1'b0;

    // Reset mid-stream with an ALU request pending
    rst_n = 1'b0;
    cycle(); cycle();
    rst_n = 1'b1;
    cycle();
    alu_valid = 1'b0;

    // Counter wrap via forced preload
    force dut.count_q = 32'hFFFF_FFFF;
    e_count = 32'hFFFF_FFFF;
    cycle();
    release dut.count_q;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hA5A5_5A5A;
    cycle();
    alu_valid = 1'b0;
    chk("count_wrap", wb_count, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      cycle();
      if (acc_alu || !alu_valid) begin
        alu_valid = 1'($urandom_range(0, 1));
        alu_rd = 5'($urandom_range(0, 31)); alu_data = $urandom;
      end
      if (acc_ld || !ld_valid) begin
        ld_valid = 1'($urandom_range(0, 1));
        ld_rd = 5'($urandom_range(0, 31)); ld_funct3 = 3'($urandom_range(0, 7));
        ld_offset = 2'($urandom_range(0, 3)); ld_data = $urandom;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
